// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC sequencer: owns the PC / inst SRAM address, holds on stalls and
// unresolved branches, redirects on taken branches (after the delay slot) and exceptions.
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_ADDR = 32'hBFC00000,
    parameter logic [31:0] EXC_ADDR   = 32'hBFC00380,
    parameter int unsigned BR_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stall_i,
    input  logic        br_pending_i,
    input  logic        br_valid_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        exc_i,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_wen,
    output logic [31:0] inst_sram_addr,
    output logic        fe_stall,
    output logic        fe_flush,
    output logic        br_err_o,
    output logic [31:0] stall_cnt_o,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        RUN     = 2'd1,
        BR_WAIT = 2'd2,
        SPARE   = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT = 8'(BR_TIMEOUT);

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [7:0]  wait_cnt, wait_cnt_next;
    logic [31:0] stall_cnt;
    logic        en, stall, flush, err;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= BOOT;
            pc        <= RESET_ADDR;
            wait_cnt  <= 8'd0;
            stall_cnt <= 32'd0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            wait_cnt <= wait_cnt_next;
            if (stall && (state != BOOT) && (stall_cnt != 32'hFFFF_FFFF))
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        wait_cnt_next = wait_cnt;
        en            = 1'b1;
        stall         = 1'b0;
        flush         = 1'b0;
        err           = 1'b0;
        case (state)
            BOOT: begin
                en         = 1'b0;
                stall      = 1'b1;
                state_next = RUN;
            end
            BR_WAIT: begin
                if (exc_i) begin
                    pc_next    = EXC_ADDR;
                    flush      = 1'b1;
                    state_next = RUN;
                end else if (stall_i) begin
                    stall = 1'b1;
                end else if (br_valid_i) begin
                    pc_next    = br_taken_i ? br_target_i : pc + 32'd4;
                    state_next = RUN;
                end else if (wait_cnt == TIMEOUT) begin
                    // Give up on decode and fall through past the delay slot
                    pc_next    = pc + 32'd4;
                    err        = 1'b1;
                    state_next = RUN;
                end else begin
                    stall         = 1'b1;
                    wait_cnt_next = wait_cnt + 8'd1;
                end
            end
            default: begin
                // RUN, and the unreachable spare encoding behaves as RUN
                state_next = RUN;
                if (exc_i) begin
                    pc_next = EXC_ADDR;
                    flush   = 1'b1;
                end else if (stall_i) begin
                    stall = 1'b1;
                end else if (br_pending_i) begin
                    pc_next       = pc + 32'd4;
                    wait_cnt_next = 8'd0;
                    state_next    = BR_WAIT;
                end else begin
                    pc_next = pc + 32'd4;
                end
            end
        endcase
        if (!resetn) begin
            en    = 1'b0;
            stall = 1'b1;
            flush = 1'b0;
            err   = 1'b0;
        end
    end

    assign inst_sram_en   = en;
    assign inst_sram_wen  = 4'b0000;
    assign inst_sram_addr = pc;
    assign fe_stall       = stall;
    assign fe_flush       = flush;
    assign br_err_o       = err;
    assign stall_cnt_o    = stall_cnt;
    assign state_o        = state;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a cycle-level behavioural model.
module tb_fetch_pc_ctrl;

    localparam logic [31:0] RST_A = 32'hBFC00000;
    localparam logic [31:0] EXC_A = 32'hBFC00380;
    localparam int          TMO   = 15;

    logic        clk = 1'b0;
    logic        resetn, stall_i, br_pending_i, br_valid_i, br_taken_i, exc_i;
    logic [31:0] br_target_i;
    logic        inst_sram_en, fe_stall, fe_flush, br_err_o;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr, stall_cnt_o;
    logic [1:0]  state_o;

    int checks = 0;
    int errors = 0;

    // model state: mode 0 boot, 1 run, 2 waiting for branch resolution
    int          m_mode;
    logic [31:0] m_pc;
    int          m_waited;
    logic [31:0] m_cnt;
    bit          m_known = 0;
    logic        last_en, last_stall, last_flush, last_err;

    fetch_pc_ctrl dut (
        .clk(clk), .resetn(resetn), .stall_i(stall_i), .br_pending_i(br_pending_i),
        .br_valid_i(br_valid_i), .br_taken_i(br_taken_i), .br_target_i(br_target_i),
        .exc_i(exc_i), .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen),
        .inst_sram_addr(inst_sram_addr), .fe_stall(fe_stall), .fe_flush(fe_flush),
        .br_err_o(br_err_o), .stall_cnt_o(stall_cnt_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: compare DUT against the model, then advance the model.
    task automatic step();
        logic        e_en, e_stall, e_flush, e_err;
        int          n_mode, n_waited;
        logic [31:0] n_pc, n_cnt;
        #1;
        e_en = 1'b1; e_stall = 1'b0; e_flush = 1'b0; e_err = 1'b0;
        n_mode = m_mode; n_pc = m_pc; n_waited = m_waited; n_cnt = m_cnt;
        if (m_mode == 0) begin
            e_en = 1'b0; e_stall = 1'b1; n_mode = 1;
        end else if (exc_i) begin
            n_pc = EXC_A; e_flush = 1'b1; n_mode = 1;
        end else if (stall_i) begin
            e_stall = 1'b1;
        end else if (m_mode == 1) begin
            n_pc = m_pc + 4;
            if (br_pending_i) begin n_mode = 2; n_waited = 0; end
        end else if (br_valid_i) begin
            n_pc = br_taken_i ? br_target_i : m_pc + 4; n_mode = 1;
        end else if (m_waited == TMO) begin
            n_pc = m_pc + 4; e_err = 1'b1; n_mode = 1;
        end else begin
            e_stall = 1'b1; n_waited = m_waited + 1;
        end
        if (e_stall && m_mode != 0 && m_cnt != 32'hFFFF_FFFF) n_cnt = m_cnt + 1;
        if (!resetn) begin
            e_en = 1'b0; e_stall = 1'b1; e_flush = 1'b0; e_err = 1'b0;
            n_mode = 0; n_pc = RST_A; n_waited = 0; n_cnt = 0;
        end
        if (m_known) begin
            chk("en", {31'd0, inst_sram_en}, {31'd0, e_en});
            chk("wen", {28'd0, inst_sram_wen}, 32'd0);
            chk("addr", inst_sram_addr, m_pc);
            chk("fe_stall", {31'd0, fe_stall}, {31'd0, e_stall});
            chk("fe_flush", {31'd0, fe_flush}, {31'd0, e_flush});
            chk("br_err", {31'd0, br_err_o}, {31'd0, e_err});
            chk("stall_cnt", stall_cnt_o, m_cnt);
            chk("state", {30'd0, state_o}, 32'(m_mode));
        end
        last_en = inst_sram_en; last_stall = fe_stall;
        last_flush = fe_flush; last_err = br_err_o;
        @(posedge clk);
        m_mode = n_mode; m_pc = n_pc; m_waited = n_waited; m_cnt = n_cnt;
        if (!resetn) m_known = 1;
        @(negedge clk);
    endtask

    task automatic idle();
        stall_i = 0; br_pending_i = 0; br_valid_i = 0; br_taken_i = 0; exc_i = 0;
        br_target_i = 32'd0;
    endtask

    initial begin
        int stall_cycles;
        resetn = 0; idle();
        m_mode = 0; m_pc = RST_A; m_waited = 0; m_cnt = 0;
        @(negedge clk);

        // reset, boot cycle, sequential fetch
        repeat (3) step();
        resetn = 1;
        chk("lit_rst_state", {30'd0, state_o}, 32'd0);
        chk("lit_rst_addr", inst_sram_addr, 32'hBFC00000);
        chk("lit_rst_cnt", stall_cnt_o, 32'd0);
        step();
        chk("lit_boot_en", {31'd0, last_en}, 32'd0);
        chk("lit_first_addr", inst_sram_addr, 32'hBFC00000);
        step();
        chk("lit_addr_04", inst_sram_addr, 32'hBFC00004);
        step();
        chk("lit_addr_08", inst_sram_addr, 32'hBFC00008);

        // hazard stall for two cycles
        stall_i = 1; step();
        chk("lit_stall_hold", inst_sram_addr, 32'hBFC00008);
        chk("lit_stall_flag", {31'd0, last_stall}, 32'd1);
        step(); stall_i = 0;
        chk("lit_stall_cnt2", stall_cnt_o, 32'd2);
        step();
        chk("lit_addr_0c", inst_sram_addr, 32'hBFC0000C);
        step();

        // taken branch resolved the next cycle
        br_pending_i = 1; step(); br_pending_i = 0;
        chk("lit_dslot", inst_sram_addr, 32'hBFC00014);
        chk("lit_brwait", {30'd0, state_o}, 32'd2);
        br_valid_i = 1; br_taken_i = 1; br_target_i = 32'hBFC00100; step(); idle();
        chk("lit_target", inst_sram_addr, 32'hBFC00100);
        step();
        chk("lit_target4", inst_sram_addr, 32'hBFC00104);
        chk("lit_cnt_nobr", stall_cnt_o, 32'd2);

        // not-taken branch resolved two cycles late
        br_pending_i = 1; step(); br_pending_i = 0;
        step(); step();
        chk("lit_late_hold", inst_sram_addr, 32'hBFC00108);
        br_valid_i = 1; step(); idle();
        chk("lit_fallthru", inst_sram_addr, 32'hBFC0010C);
        chk("lit_cnt_late", stall_cnt_o, 32'd4);

        // exception while waiting on a branch
        br_pending_i = 1; step(); br_pending_i = 0;
        exc_i = 1; step(); exc_i = 0;
        chk("lit_exc_addr", inst_sram_addr, EXC_A);
        chk("lit_exc_flush", {31'd0, last_flush}, 32'd1);
        chk("lit_exc_state", {30'd0, state_o}, 32'd1);

        // branch never resolved: timeout after TMO+1 waiting cycles
        br_pending_i = 1; step(); br_pending_i = 0;
        for (int k = 0; k <= TMO; k++) step();
        chk("lit_tmo_err", {31'd0, last_err}, 32'd1);
        chk("lit_tmo_addr", inst_sram_addr, 32'hBFC00388);
        chk("lit_tmo_cnt", stall_cnt_o, 32'd19);

        // reset in the middle of a stalled branch wait
        br_pending_i = 1; step(); br_pending_i = 0;
        stall_i = 1; step();
        resetn = 0; step();
        chk("lit_rst2_state", {30'd0, state_o}, 32'd0);
        chk("lit_rst2_addr", inst_sram_addr, 32'hBFC00000);
        chk("lit_rst2_cnt", stall_cnt_o, 32'd0);
        resetn = 1; idle();

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            resetn       = ($urandom_range(0, 299) != 0);
            exc_i        = ($urandom_range(0, 49) == 0);
            stall_i      = ($urandom_range(0, 7) == 0);
            br_pending_i = ($urandom_range(0, 5) == 0);
            br_valid_i   = ($urandom_range(0, 13) == 0);
            br_taken_i   = $urandom_range(0, 1) == 1;
            br_target_i  = $urandom();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
